// File: rtl/core_exec_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional feature macro CORE_DIV_EARLY_OUT_EN: divide-by-zero finishes one cycle after accept.
module core_exec_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic [1:0]  div_op,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        div_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem, quo, abs_b;
  logic          neg_q, neg_r, div0, rem_sel;
  logic          accept, last, early;

  logic          sgn_in;
  logic [W-1:0]  abs_a_in, abs_b_in;
  logic [W:0]    rem_hi;
  logic          ge;
  logic [W-1:0]  diff, rem_nxt, quo_nxt, q_fin, r_fin, result_fin;

  // Operand conditioning at accept time
  assign sgn_in   = ~div_op[0];
  assign abs_a_in = (sgn_in & div_a[W-1]) ? (~div_a + W'(1)) : div_a;
  assign abs_b_in = (sgn_in & div_b[W-1]) ? (~div_b + W'(1)) : div_b;

`ifdef CORE_DIV_EARLY_OUT_EN
  assign early = (div_b == '0);
`else
  assign early = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, subtract divisor if it fits
  always_comb begin
    rem_hi = {rem, quo[W-1]};
    ge     = (rem_hi >= {1'b0, abs_b});
    diff   = W'(rem_hi - {1'b0, abs_b});
    if (ge) begin
      rem_nxt = diff;
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = rem_hi[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

  // Sign fix-up; the overflow case wraps to 0x80000000 on its own
  always_comb begin
    q_fin      = div0 ? '1 : (neg_q ? (~quo_nxt + W'(1)) : quo_nxt);
    r_fin      = neg_r ? (~rem_nxt + W'(1)) : rem_nxt;
    result_fin = rem_sel ? r_fin : q_fin;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_start) begin
          accept    = 1'b1;
          state_nxt = early ? DONE : ITER;
        end
      end
      ITER: begin
        if (cnt == CW'(W - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (div_flush) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      last      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_busy <= (state_nxt != IDLE);
      div_done <= (state_nxt == DONE);
    end
  end

  // Datapath: latch operands on accept, iterate in ITER, write result entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      abs_b      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div0       <= 1'b0;
      rem_sel    <= 1'b0;
      div_result <= '0;
    end else begin
      if (accept) begin
        neg_q   <= sgn_in & (div_a[W-1] ^ div_b[W-1]) & (div_b != '0);
        neg_r   <= sgn_in & div_a[W-1];
        div0    <= (div_b == '0);
        rem_sel <= div_op[1];
        abs_b   <= abs_b_in;
        rem     <= '0;
        quo     <= abs_a_in;
        cnt     <= '0;
        if (early) div_result <= div_op[1] ? div_a : '1;
      end else if (state == ITER && !div_flush) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CW'(1);
        if (last) div_result <= result_fin;
      end
      if (div_flush) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_core_exec_div.sv
// Scoreboard bench for core_exec_div: directed corner cases, flush, reset, held start, random ops.
module tb_core_exec_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start, div_flush;
  logic [1:0]  div_op;
  logic [31:0] div_a, div_b;
  logic        div_busy, div_done;
  logic [31:0] div_result;

  core_exec_div dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_op(div_op),
    .div_a(div_a), .div_b(div_b), .div_flush(div_flush),
    .div_busy(div_busy), .div_done(div_done), .div_result(div_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          accq[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model_last = '0;
  bit          busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] model_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return 32'($signed(a) / $signed(b));
      2'd1: return a / b;
      2'd2: if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Sampled-cycle offset from accept edge to the cycle where done is seen
  function automatic int latency(input logic [31:0] b);
`ifdef CORE_DIV_EARLY_OUT_EN
    return (b == 32'd0) ? 0 : 32;
`else
    return (b == 32'd0) ? 32 : 32;
`endif
  endfunction

  // Monitor: record accepts (busy rising) and check every done against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (div_busy && !busy_prev) accq.push_back(cyc);
      if (div_done) begin
        if (sbq.size() == 0 || accq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          int   t;
          e = sbq.pop_front();
          t = accq.pop_front();
          check("result", div_result, e.res);
          check("latency", 32'(cyc - t), 32'(e.lat));
        end
      end
      busy_prev = div_busy;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && div_busy; i++) begin
      @(posedge clk); #1;
    end
    if (div_busy) fail_now("idle_timeout");
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    wait_idle();
    div_op = op; div_a = a; div_b = b; div_start = 1'b1;
    if (expect_done) begin
      e.res = model_div(op, a, b);
      e.lat = latency(b);
      sbq.push_back(e);
      model_last = e.res;
    end
    @(posedge clk); #1;
    div_start = 1'b0;
    div_op = 2'($urandom); div_a = $urandom; div_b = $urandom;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    exp_t        e;

    rst = 1'b1; div_start = 1'b0; div_flush = 1'b0;
    div_op = '0; div_a = '0; div_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, div_busy}, 32'd0);
    check("reset_done", {31'd0, div_done}, 32'd0);
    check("reset_result", div_result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(2'd1, 32'd100, 32'd7, 1'b1);
    issue(2'd3, 32'd100, 32'd7, 1'b1);
    issue(2'd0, 32'hFFFF_FF9C, 32'd7, 1'b1);
    issue(2'd2, 32'hFFFF_FF9C, 32'd7, 1'b1);
    issue(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b1);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'd1, 32'h1234_5678, 32'd0, 1'b1);
    issue(2'd0, 32'h1234_5678, 32'd0, 1'b1);
    issue(2'd2, 32'h1234_5678, 32'd0, 1'b1);
    issue(2'd3, 32'h8765_4321, 32'd0, 1'b1);

    // Flush mid-operation: accept at T, flush sampled at T+10, restart at T+11
    issue(2'd1, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1; div_flush = 1'b1;
    @(posedge clk); #1; div_flush = 1'b0;
    check("flush_busy", {31'd0, div_busy}, 32'd0);
    check("flush_result_held", div_result, model_last);
    if (accq.size() > 0) void'(accq.pop_front());
    issue(2'd1, 32'd9, 32'd3, 1'b1);

    // Flush together with start: nothing accepted
    wait_idle();
    div_op = 2'd1; div_a = 32'd50; div_b = 32'd5; div_start = 1'b1; div_flush = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; div_flush = 1'b0;
    check("flush_start_busy", {31'd0, div_busy}, 32'd0);

    // Reset mid-operation
    issue(2'd1, 32'd1000, 32'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_done", {31'd0, div_done}, 32'd0);
    check("midrst_result", div_result, 32'd0);
    sbq.delete();
    accq.delete();
    model_last = '0;
    @(posedge clk); #1; rst = 1'b0;
    issue(2'd3, 32'd1000, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("postrst_result_zero", div_result, 32'd0);

    // Start held high through DONE: next accept only after an IDLE cycle
    wait_idle();
    div_op = 2'd1; div_a = 32'd100; div_b = 32'd7; div_start = 1'b1;
    e.res = 32'd14; e.lat = 32;
    sbq.push_back(e);
    sbq.push_back(e);
    begin
      int i;
      for (i = 0; i < 100 && !div_done; i++) begin
        @(posedge clk); #1;
      end
      if (!div_done) fail_now("held_done_timeout");
    end
    @(posedge clk); #1;
    check("held_idle_busy", {31'd0, div_busy}, 32'd0);
    check("held_idle_done", {31'd0, div_done}, 32'd0);
    @(posedge clk); #1;
    check("held_reaccept_busy", {31'd0, div_busy}, 32'd1);
    div_start = 1'b0;

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: rb = ~32'($urandom_range(0, 15));
        4: begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1'b1);
    end

    for (int i = 0; i < 200 && sbq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (sbq.size() > 0) fail_now("drain_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_exec_div.md
Name: core_exec_div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits directly upstream of the execute-stage result mux and feeds its div_result input.
- Accepts one operation at a time under a start/busy/done handshake. The execute stage stalls on busy.
- Produces a 32-bit quotient or remainder with RISC-V-mandated corner-case results.

Parameters:
- None. Width is fixed at 32 (RV32).

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous, active-high reset
- div_start  input  1  request a new operation; accepted only when busy=0 and div_flush=0
- div_op  input  2  operation: 0=DIV, 1=DIVU, 2=REM, 3=REMU; sampled on accept
- div_a  input  32  dividend (rs1); sampled on accept
- div_b  input  32  divisor (rs2); sampled on accept
- div_flush  input  1  abort any operation in flight (pipeline kill/trap)
- div_busy  output  1  operation in flight; high from the cycle after accept until the cycle done is high, inclusive
- div_done  output  1  single-cycle pulse; div_result is valid in this cycle
- div_result  output  32  quotient or remainder; held stable from done until the next accept

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, div_busy=0, div_done=0, div_result=0, iteration counter=0.

State machine (IDLE, ITER, DONE):
- IDLE: accept when div_start=1 and div_flush=0, then go to ITER.
- On accept, latch:
  - signed = (op==DIV or op==REM);
  - |a| and |b| (two's-complement negate when signed and the MSB is set);
  - neg_q = signed & (a[31]^b[31]) & (b!=0);
  - neg_r = signed & a[31];
  - div0 = (b==0);
  - rem_sel = op[1].
- ITER: 32 cycles, counter 0..31.
  - Each cycle: shift {rem,quo} left 1; trial = rem_hi - |b| (33-bit).
  - If trial is non-negative, rem_hi = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - At counter=31, go to DONE.
- DONE: div_done=1 for exactly one cycle, and div_result is written on the entry edge.
  - Then go to IDLE.
  - A div_start while in DONE is not accepted, because busy=1.

Final result:
- div0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original div_a.
- Otherwise:
  - quotient = neg_q ? -quo : quo
  - remainder = neg_r ? -rem : rem
- Overflow (DIV of 0x80000000 by 0xFFFFFFFF) falls out naturally: |a| = 2^31 as unsigned, quo = 0x80000000, and its negation is 0x80000000; rem = 0. No special path is required, but this case must be verified.

Timing and control:
- Latency: accept at edge T; div_done is high in cycle T+33; div_busy is high in cycles T+1..T+33.
- div_flush in any state: go to IDLE next edge. div_done is suppressed that cycle; div_result is unchanged; the counter is cleared.
- div_flush together with div_start: flush wins and nothing is accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values. No done pulse is produced.
- div_a, div_b and div_op may change freely after accept; the block uses only its latched copies.

Optional Feature:
- Macro: CORE_DIV_EARLY_OUT_EN.
- When defined:
  - An accepted operation with b==0 skips ITER and goes directly to DONE.
  - div_done is high in cycle T+1 with the div0 result; div_busy is high only in T+1.
  - All other operations keep 33-cycle latency.
- When undefined:
  - div0 operations still run all 32 iterations.
  - div_done is high in T+33 with an identical result value.

Test Plan:
- DIVU a=100, b=7, accepted at T -> busy in T+1..T+33; done in T+33; result=14. Repeat with REMU -> result=2.
- DIV a=0xFFFFFF9C (-100), b=7 -> 0xFFFFFFF2 (-14). REM with the same operands -> 0xFFFFFFFE (-2). REM a=100, b=0xFFFFFFF9 (-7) -> 2.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- DIVU/DIV a=0x12345678, b=0 -> 0xFFFFFFFF; REM a=0x12345678, b=0 -> 0x12345678.
  - Done at T+33 without CORE_DIV_EARLY_OUT_EN, at T+1 with it.
- Start DIVU 100/7, then assert div_flush at T+10 -> no done pulse, busy=0 from T+11, result keeps its old value. A new start at T+11 (DIVU 9/3) -> done at T+44, result=3.
- Assert rst at T+5 of an operation -> busy, done and result are 0 immediately and stay 0 until the next accepted operation completes. div_start held high during DONE -> no second accept until IDLE.
